cart_loader: RTL and testbench

Cartridge ROM loader: the write-side counterpart of the MBC1 mapper's read path. It takes a framed byte stream from the UART receiver and writes the ROM image into cartridge SRAM starting at address 0x0000. It verifies an 8-bit checksum and returns a one-byte ACK/NAK through the UART transmitter. While a load is in progress it holds `prog` high, so the mapper and CPU are kept off the SRAM.

---
 rtl/cart_loader.sv | 82 ++++++++
 tb/tb_cart_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_loader.sv
// cart_loader: receives a framed ROM image over UART, writes it to SRAM and answers ACK/NAK
module cart_loader #(
  parameter logic [7:0] SYNC = 8'h55,
  parameter logic [7:0] ACK = 8'h06,
  parameter logic [7:0] NAK = 8'h15
) (
  input  logic        clockgb,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] prog_address,
  output logic [7:0]  prog_data,
  output logic        prog_store,
  output logic        prog,
  output logic        done,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, LENHI, LENLO, DATA, SUM, RESP} state_t;
  state_t state;
  logic [15:0] len;
  logic [15:0] count;
  logic [7:0] sum;
  // frame parser; write strobe and done are single-cycle pulses defaulting low
  always_ff @(posedge clockgb) begin
    prog_store <= 1'b0;
    done <= 1'b0;
    if (reset) begin
      state <= IDLE;
      len <= '0;
      count <= '0;
      sum <= '0;
      prog <= 1'b0;
      error <= 1'b0;
      tx_valid <= 1'b0;
      tx_data <= '0;
      prog_address <= '0;
      prog_data <= '0;
    end else begin
      case (state)
        IDLE: if (rx_valid && rx_data == SYNC) begin
          state <= LENHI;
          prog <= 1'b1;
          error <= 1'b0;
          sum <= '0;
          count <= '0;
        end
        LENHI: if (rx_valid) begin
          len[15:8] <= rx_data;
          state <= LENLO;
        end
        LENLO: if (rx_valid) begin
          len[7:0] <= rx_data;
          state <= ({len[15:8], rx_data} == 16'd0) ? SUM : DATA;
        end
        DATA: if (rx_valid) begin
          prog_data <= rx_data;
          prog_address <= count;
          prog_store <= 1'b1;
          sum <= sum + rx_data;
          count <= count + 16'd1;
          if (count + 16'd1 == len) state <= SUM;
        end
        SUM: if (rx_valid) begin
          error <= rx_data != sum;
          tx_data <= (rx_data == sum) ? ACK : NAK;
          tx_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (tx_ready) begin
          tx_valid <= 1'b0;
          done <= 1'b1;
          prog <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cart_loader.sv
// tb_cart_loader: randomized frame loads checked against a simple frame/checksum model
module tb_cart_loader;
  typedef logic [7:0] bq_t [$];
  logic clockgb = 1'b0;
  logic reset = 1'b1;
  logic rx_valid = 1'b0;
  logic tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] tx_data;
  logic tx_valid;
  logic [15:0] prog_address;
  logic [7:0] prog_data;
  logic prog_store;
  logic prog;
  logic done;
  logic error;
  int errs = 0;
  int checks = 0;
  logic [23:0] wq[$];

  cart_loader dut (
    .clockgb(clockgb), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .prog_address(prog_address), .prog_data(prog_data), .prog_store(prog_store),
    .prog(prog), .done(done), .error(error)
  );

  always #5 clockgb = ~clockgb;

  // every cycle with prog_store high is one SRAM write
  always @(negedge clockgb) if (prog_store === 1'b1) wq.push_back({prog_address, prog_data});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b, input bit b2b);
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clockgb);
    rx_valid = 1'b0;
    if (!b2b) repeat ($urandom_range(2, 0)) @(negedge clockgb);
  endtask

  task automatic run_frame(input bq_t d, input logic [7:0] s, input bit b2b, input int hold);
    int n;
    int tot;
    logic [15:0] len;
    logic [7:0] exp_sum;
    logic [7:0] exp_tx;
    logic nak;
    n = d.size();
    tot = 0;
    foreach (d[i]) tot += int'(d[i]);
    exp_sum = 8'(tot % 256);
    nak = (s != exp_sum);
    exp_tx = nak ? 8'h15 : 8'h06;
    len = 16'(n);
    wq.delete();
    send(8'h55, b2b);
    checks++;
    if (prog !== 1'b1 || error !== 1'b0) begin
      errs++;
      $display("FAIL sync_start: prog=%b error=%b expected prog=1 error=0", prog, error);
    end
    send(len[15:8], b2b);
    send(len[7:0], b2b);
    foreach (d[i]) send(d[i], b2b);
    send(s, 1'b1);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== exp_tx || error !== nak) begin
      errs++;
      $display("FAIL response: tx_valid=%b tx_data=%h error=%b expected 1 %h %b", tx_valid, tx_data, error, exp_tx, nak);
    end
    for (int i = 0; i < hold; i++) begin
      rx_valid = (i == 0);
      rx_data = 8'h55;
      @(negedge clockgb);
      rx_valid = 1'b0;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_tx || done !== 1'b0 || prog !== 1'b1) begin
        errs++;
        $display("FAIL resp_hold: cycle %0d tx_valid=%b tx_data=%h done=%b prog=%b expected 1 %h 0 1", i, tx_valid, tx_data, done, prog, exp_tx);
      end
    end
    tx_ready = 1'b1;
    @(negedge clockgb);
    tx_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || prog !== 1'b0 || tx_valid !== 1'b0) begin
      errs++;
      $display("FAIL handshake: done=%b prog=%b tx_valid=%b expected 1 0 0", done, prog, tx_valid);
    end
    @(negedge clockgb);
    checks++;
    if (done !== 1'b0 || error !== nak) begin
      errs++;
      $display("FAIL after_done: done=%b error=%b expected 0 %b", done, error, nak);
    end
    checks++;
    if (wq.size() != n) begin
      errs++;
      $display("FAIL write_count: got %0d expected %0d", wq.size(), n);
    end
    for (int i = 0; i < n && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== {16'(i), d[i]}) begin
        errs++;
        $display("FAIL write_%0d: got addr/data %h expected %h", i, wq[i], {16'(i), d[i]});
      end
    end
    if (n > 0) begin
      checks++;
      if (prog_address !== 16'(n - 1) || prog_data !== d[n-1]) begin
        errs++;
        $display("FAIL write_hold: addr=%h data=%h expected %h %h", prog_address, prog_data, 16'(n - 1), d[n-1]);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clockgb);
    reset = 1'b0;
    checks++;
    if ({prog, prog_store, tx_valid, done, error} !== 5'b0 || tx_data !== 8'h00 || prog_address !== 16'h0000 || prog_data !== 8'h00) begin
      errs++;
      $display("FAIL reset_values: flags=%b tx_data=%h addr=%h data=%h expected all zero",
               {prog, prog_store, tx_valid, done, error}, tx_data, prog_address, prog_data);
    end
    send(8'h12, 1'b0);
    checks++;
    if (prog !== 1'b0) begin
      errs++;
      $display("FAIL idle_ignore: prog=%b expected 0", prog);
    end
  endtask

  task automatic test_ack;
    bq_t d;
    d = '{8'h10, 8'h20, 8'h30};
    run_frame(d, 8'h60, 1'b0, 2);
  endtask

  task automatic test_nak;
    bq_t d;
    d = '{8'h10, 8'h20, 8'h30};
    run_frame(d, 8'h61, 1'b0, 1);
    send(8'h33, 1'b0);
    checks++;
    if (error !== 1'b1 || prog !== 1'b0) begin
      errs++;
      $display("FAIL sticky_error: error=%b prog=%b expected 1 0", error, prog);
    end
  endtask

  task automatic test_zero_len;
    bq_t d;
    d.delete();
    run_frame(d, 8'h00, 1'b0, 0);
    run_frame(d, 8'h01, 1'b1, 0);
  endtask

  task automatic test_wrap;
    bq_t d;
    d = '{8'hFF, 8'h02};
    run_frame(d, 8'h01, 1'b0, 1);
    d.delete();
    for (int i = 0; i < 85; i++) d.push_back(8'h55);
    run_frame(d, 8'h39, 1'b1, 0);
  endtask

  task automatic test_back_to_back;
    bq_t d;
    int t;
    t = 0;
    for (int i = 0; i < 256; i++) begin
      d.push_back(8'($urandom));
      t += int'(d[i]);
    end
    run_frame(d, 8'(t), 1'b1, 10);
  endtask

  task automatic test_reset_midframe;
    bq_t d;
    wq.delete();
    send(8'h55, 1'b1);
    send(8'h00, 1'b1);
    send(8'h04, 1'b1);
    send(8'hA1, 1'b1);
    send(8'hB2, 1'b1);
    reset = 1'b1;
    @(negedge clockgb);
    reset = 1'b0;
    checks++;
    if (prog !== 1'b0 || prog_store !== 1'b0 || tx_valid !== 1'b0) begin
      errs++;
      $display("FAIL midframe_reset: prog=%b prog_store=%b tx_valid=%b expected 0 0 0", prog, prog_store, tx_valid);
    end
    checks++;
    if (wq.size() != 2) begin
      errs++;
      $display("FAIL midframe_writes: got %0d expected 2", wq.size());
    end
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(d, 8'h0A, 1'b0, 0);
  endtask

  task automatic test_random;
    bq_t d;
    int n;
    int t;
    logic [7:0] s;
    for (int k = 0; k < 6; k++) begin
      d.delete();
      n = $urandom_range(40, 0);
      t = 0;
      for (int i = 0; i < n; i++) begin
        d.push_back(8'($urandom));
        t += int'(d[i]);
      end
      s = 8'(t);
      if ($urandom_range(1, 0) == 1) s = s ^ 8'($urandom_range(255, 1));
      run_frame(d, s, 1'($urandom_range(1, 0)), $urandom_range(3, 0));
    end
  endtask

  initial begin
    test_reset;
    test_ack;
    test_nak;
    test_zero_len;
    test_wrap;
    test_back_to_back;
    test_reset_midframe;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
